// File: rtl/edge_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : edge_packer                                                   |
// | Purpose  : Binarises one frame of edge-filter pixels on request, packs   |
// |            8 pixels per byte (bit0 = earliest pixel), zero-pads the last |
// |            byte of each line and streams the bytes out through a        |
// |            first-word-fall-through FIFO with a ready/valid handshake.    |
// | Ports    : clk, rst (async, active-high)                                 |
// |            i_vsync/i_hsync/i_de/i_data : pixel stream in                 |
// |            i_arm        : request capture of the next full frame         |
// |            o_tdata/o_tvalid/o_tlast/i_tready : byte stream out           |
// |            o_busy       : armed or capturing                             |
// |            o_frame_done : pulse when the final frame byte enters FIFO    |
// |            o_overflow   : sticky, a byte was lost or frame cut short     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module edge_packer #(
  parameter int H_RES      = 172,
  parameter int V_RES      = 240,
  parameter int BIN_TH     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vsync,
  input  logic       i_hsync,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic       i_arm,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_tlast,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overflow
);

  localparam int PW = $clog2(H_RES + 1);
  localparam int LW = $clog2(V_RES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] c_H_RES  = PW'(H_RES);
  localparam logic [PW-1:0] c_H_LAST = PW'(H_RES - 1);
  localparam logic [LW-1:0] c_V_LAST = LW'(V_RES - 1);
  localparam logic [7:0]    c_TH     = 8'(BIN_TH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_vsync_d;
  logic            r_de_d;
  logic [PW-1:0]   r_pix;
  logic [LW-1:0]   r_line;
  logic [2:0]      r_bit;
  logic [7:0]      r_pack;
  logic            r_wr_en;
  logic            r_wr_last;
  logic [7:0]      r_wr_data;
  logic            r_frame_done;
  logic            r_overflow;
  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wp;
  logic [AW:0]     r_rp;

  logic            w_empty;
  logic            w_full;
  logic            w_rd;
  logic            w_wr_ok;
  logic            w_stop;
  logic            w_vs_rise;
  logic            w_de_fall;
  logic            w_pix_bit;
  logic            w_take;
  logic            w_last_line;
  logic [7:0]      w_byte;
  logic            w_unused_hsync;

  // Line sync carries no information the pixel-valid strobe does not.
  assign w_unused_hsync = i_hsync;

  // ---------------- FIFO status ----------------
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd    = ~w_empty & i_tready;
  // A full FIFO still accepts a byte when the head is leaving in the same cycle.
  assign w_wr_ok = r_wr_en & (~w_full | w_rd);

  // ---------------- capture datapath ----------------
  assign w_vs_rise   = i_vsync & ~r_vsync_d;
  assign w_de_fall   = r_de_d & ~i_de;
  assign w_pix_bit   = (i_data >= c_TH);
  assign w_take      = (r_state == S_CAPTURE) && i_de && (r_pix < c_H_RES);
  assign w_last_line = (r_line == c_V_LAST);
  // Bits are placed by index so unfilled upper bits stay zero for padding.
  assign w_byte      = r_pack | ({7'd0, w_pix_bit} << r_bit);
  // The pending write ends the capture if it fails or if it is the frame's last byte.
  assign w_stop      = r_wr_en & (r_wr_last | ~w_wr_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vsync_d    <= 1'b0;
      r_de_d       <= 1'b0;
      r_pix        <= '0;
      r_line       <= '0;
      r_bit        <= 3'd0;
      r_pack       <= 8'd0;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_wr_data    <= 8'd0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_vsync_d    <= i_vsync;
      r_de_d       <= i_de;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_frame_done <= r_wr_en & w_wr_ok & r_wr_last;

      case (r_state)
        S_IDLE: begin
          if (i_arm) begin
            r_state    <= S_ARMED;
            r_overflow <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_vs_rise) begin
            r_state <= S_CAPTURE;
            r_pix   <= '0;
            r_line  <= '0;
            r_bit   <= 3'd0;
            r_pack  <= 8'd0;
          end
        end
        S_CAPTURE: begin
          if (w_stop) begin
            r_state <= S_IDLE;
          end else if (w_vs_rise) begin
            // New frame before this one completed: flush what we have and flag it.
            if (r_bit != 3'd0) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= r_pack;
            end
            r_overflow <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_take) begin
            r_pix <= r_pix + 1'b1;
            if (r_bit == 3'd7) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_byte;
              // Only reachable when H_RES is a multiple of 8.
              r_wr_last <= w_last_line && (r_pix == c_H_LAST);
              r_pack    <= 8'd0;
              r_bit     <= 3'd0;
            end else begin
              r_pack <= w_byte;
              r_bit  <= r_bit + 3'd1;
            end
          end else if (w_de_fall && (r_pix != '0)) begin
            // End of line; the guard ignores a line already in flight at capture start.
            if (r_bit != 3'd0) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= r_pack;
              r_wr_last <= w_last_line;
            end
            r_pack <= 8'd0;
            r_bit  <= 3'd0;
            r_pix  <= '0;
            r_line <= r_line + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_wr_en && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------- FIFO storage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + 1'b1;
      if (w_rd)    r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wp[AW-1:0]] <= {r_wr_last, r_wr_data};
    end
  end

  // Head word is forced to zero when empty so outputs read 0 during and after reset.
  assign {o_tlast, o_tdata} = w_empty ? 9'd0 : r_mem[r_rp[AW-1:0]];
  assign o_tvalid           = ~w_empty;
  assign o_busy             = (r_state != S_IDLE);
  assign o_frame_done       = r_frame_done;
  assign o_overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_edge_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_edge_packer                                                |
// | Purpose  : Self-checking bench for edge_packer. Two instances: a 2-line  |
// |            one for directed frame scenarios and a full 240-line one for  |
// |            a randomly back-pressured frame. Expected bytes come from a   |
// |            line-level packing model fed with the same pixels.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_edge_packer;

  localparam int H   = 172;
  localparam int TH  = 128;
  localparam int GAP = 4;
  localparam int BIG = 1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_vsync = 1'b0;
  logic       i_hsync = 1'b0;
  logic       i_de = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       arm_a = 1'b0;
  logic       arm_b = 1'b0;
  logic       tready = 1'b0;

  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, a_tlast, a_busy, a_fd, a_ovf;
  logic       b_tvalid, b_tlast, b_busy, b_fd, b_ovf;

  always #5 clk = ~clk;

  edge_packer #(.H_RES(H), .V_RES(2), .BIN_TH(TH), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_data(i_data), .i_arm(arm_a), .o_tdata(a_tdata), .o_tvalid(a_tvalid),
    .i_tready(tready), .o_tlast(a_tlast), .o_busy(a_busy),
    .o_frame_done(a_fd), .o_overflow(a_ovf)
  );

  edge_packer #(.H_RES(H), .V_RES(240), .BIN_TH(TH), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_data(i_data), .i_arm(arm_b), .o_tdata(b_tdata), .o_tvalid(b_tvalid),
    .i_tready(tready), .o_tlast(b_tlast), .o_busy(b_busy),
    .o_frame_done(b_fd), .o_overflow(b_ovf)
  );

  // Stream monitor follows one instance at a time.
  logic sel = 1'b0;
  wire        m_tvalid = sel ? b_tvalid : a_tvalid;
  wire        m_tlast  = sel ? b_tlast  : a_tlast;
  wire  [7:0] m_tdata  = sel ? b_tdata  : a_tdata;
  wire        m_fd     = sel ? b_fd     : a_fd;

  int         n_checks = 0;
  int         n_errors = 0;
  int         rx_cnt   = 0;
  int         fd_cnt   = 0;
  int         cap_left = 0;
  int         tr_mode  = 1;
  logic [8:0] exp_q [$];

  // ---------------- output monitor (samples on falling edge) ----------------
  initial begin
    logic       prev_stall;
    logic [8:0] prev_word;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_word  = 9'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          assert ({m_tvalid, m_tlast, m_tdata} === {1'b1, prev_word}) else begin
            n_errors++;
            $error("FAIL stall_hold observed=%h expected=%h", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_word});
          end
        end
        if (m_fd) fd_cnt++;
        if (m_tvalid && tready) begin
          rx_cnt++;
          n_checks++;
          assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL extra_byte observed=%h expected=none", {m_tlast, m_tdata});
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            assert ({m_tlast, m_tdata} === e) else begin
              n_errors++;
              $error("FAIL byte_%0d observed=%h expected=%h", rx_cnt, {m_tlast, m_tdata}, e);
            end
          end
        end
        prev_stall = m_tvalid && !tready;
        prev_word  = {m_tlast, m_tdata};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int c);
    int r;
    case (mode)
      0: return 8'hFF;
      1: return (c % 2 == 1) ? 8'hFF : 8'h00;
      2: return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      default: begin
        r = $urandom_range(0, 4);
        case (r)
          0:       return 8'd127;
          1:       return 8'd128;
          2:       return 8'd0;
          3:       return 8'd255;
          default: return 8'($urandom_range(0, 255));
        endcase
      end
    endcase
  endfunction

  // Drives one line; the model packs the first min(npix,H) pixels into
  // ceil(n/8) bytes, LSB = earliest pixel, and queues up to cap_left of them.
  task automatic send_line(input int mode, input int npix, input bit last_line,
                           input int arm_at, input int gap);
    logic [7:0] px [$];
    int n, nb, b;
    for (int c = 0; c < npix; c++) px.push_back(pix_val(mode, c));
    n  = (npix < H) ? npix : H;
    nb = (n + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b = 0;
      for (int j = 0; j < 8; j++) begin
        if ((8 * k + j < n) && (px[8 * k + j] >= 8'(TH))) b += (1 << j);
      end
      if (cap_left > 0) begin
        exp_q.push_back({last_line && (k == nb - 1), 8'(b)});
        cap_left--;
      end
    end
    for (int c = 0; c < npix; c++) begin
      i_de   = 1'b1;
      i_data = px[c];
      arm_a  = (c == arm_at);
      step();
    end
    arm_a = 1'b0;
    if (gap > 0) begin
      i_de   = 1'b0;
      i_data = 8'd0;
      repeat (gap) step();
    end
  endtask

  task automatic vs_pulse();
    i_vsync = 1'b1;
    step();
    step();
    i_vsync = 1'b0;
    step();
    step();
  endtask

  task automatic send_frame(input int mode, input int nlines, input int arm_at, input int extra);
    vs_pulse();
    for (int l = 0; l < nlines; l++) begin
      send_line(mode, H + extra, (l == nlines - 1), (l == 0) ? arm_at : -1, GAP);
    end
  endtask

  task automatic arm_pulse(input bit which_b);
    if (which_b) arm_b = 1'b1;
    else         arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    arm_b = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < limit) begin
      step();
      t++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_tlast", a_tlast, 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_fdone", a_fd, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_b_tvalid", b_tvalid, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    step();

    // Frames without arm produce nothing
    cap_left = 0;
    send_frame(2, 2, -1, 0);
    send_frame(0, 2, -1, 0);
    chk("noarm_tvalid", a_tvalid, 0);
    chk("noarm_busy", a_busy, 0);
    chk("noarm_rx", rx_cnt, 0);

    // All-255 frame: 21x FF + 0F per line, tlast on byte 44
    arm_pulse(0);
    chk("arm_busy", a_busy, 1);
    rx_cnt = 0; fd_cnt = 0; cap_left = BIG;
    send_frame(0, 2, -1, 0);
    drain("ones", 200);
    chk("ones_rx", rx_cnt, 44);
    chk("ones_fdone", fd_cnt, 1);
    chk("ones_busy", a_busy, 0);
    chk("ones_ovf", a_ovf, 0);

    // Alternating 0,255: AA bytes, 0A pad byte
    arm_pulse(0);
    rx_cnt = 0; cap_left = BIG;
    send_frame(1, 2, -1, 0);
    drain("alt", 200);
    chk("alt_rx", rx_cnt, 44);

    // Threshold boundary values, with extra pixels beyond H_RES on every line
    arm_pulse(0);
    rx_cnt = 0; fd_cnt = 0; cap_left = BIG;
    send_frame(3, 2, -1, 5);
    drain("extra", 200);
    chk("extra_rx", rx_cnt, 44);
    chk("extra_fdone", fd_cnt, 1);

    // Arm mid-frame: that frame is skipped, the next one captured from line 0
    cap_left = 0;
    send_frame(2, 2, 10, 0);
    chk("midarm_busy", a_busy, 1);
    chk("midarm_tvalid", a_tvalid, 0);
    rx_cnt = 0; cap_left = BIG;
    send_frame(3, 2, -1, 0);
    drain("midarm", 200);
    chk("midarm_rx", rx_cnt, 44);

    // No consumer: 16 bytes held, overflow, then exactly 16 drain
    tr_mode = 0;
    arm_pulse(0);
    rx_cnt = 0; fd_cnt = 0; cap_left = 16;
    send_frame(2, 2, -1, 0);
    chk("full_ovf", a_ovf, 1);
    chk("full_busy", a_busy, 0);
    chk("full_tvalid", a_tvalid, 1);
    chk("full_fdone", fd_cnt, 0);
    tr_mode = 1;
    drain("full", 100);
    chk("full_rx", rx_cnt, 16);
    chk("full_ovf_sticky", a_ovf, 1);
    arm_pulse(0);
    chk("arm_clr_ovf", a_ovf, 0);

    // Vsync before frame completes: partial byte flushed, overflow, idle
    rx_cnt = 0; fd_cnt = 0; cap_left = BIG;
    vs_pulse();
    send_line(2, H, 1'b0, -1, GAP);
    send_line(2, 20, 1'b0, -1, 0);
    i_de    = 1'b0;
    i_vsync = 1'b1;
    step();
    chk("early_busy", a_busy, 0);
    chk("early_ovf", a_ovf, 1);
    i_vsync = 1'b0;
    step();
    drain("early", 100);
    chk("early_rx", rx_cnt, 25);
    chk("early_fdone", fd_cnt, 0);

    // Write latency, then asynchronous reset mid-frame
    arm_pulse(0);
    cap_left = 0; tr_mode = 0;
    vs_pulse();
    for (int c = 0; c < 90; c++) begin
      i_de   = 1'b1;
      i_data = 8'hFF;
      step();
      if (c == 7) chk("lat_edge_t", a_tvalid, 0);
      if (c == 8) begin
        chk("lat_edge_t1", a_tvalid, 1);
        chk("lat_first_byte", a_tdata, 8'hFF);
      end
    end
    chk("pre_rst_tvalid", a_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", a_tvalid, 0);
    chk("async_rst_busy", a_busy, 0);
    step();
    rst  = 1'b0;
    i_de = 1'b0;
    repeat (GAP) step();
    tr_mode = 1; rx_cnt = 0;
    send_frame(2, 2, -1, 0);
    chk("post_rst_rx", rx_cnt, 0);
    chk("post_rst_tvalid", a_tvalid, 0);
    arm_pulse(0);
    cap_left = BIG;
    send_frame(3, 2, -1, 0);
    drain("rearm", 200);
    chk("rearm_rx", rx_cnt, 44);

    // Full 172x240 frame under random back-pressure
    sel = 1'b1;
    tr_mode = 2; rx_cnt = 0; fd_cnt = 0; cap_left = BIG;
    arm_pulse(1);
    send_frame(2, 240, -1, 0);
    drain("big", 4000);
    chk("big_rx", rx_cnt, 5280);
    chk("big_fdone", fd_cnt, 1);
    chk("big_ovf", b_ovf, 0);
    chk("big_busy", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
